// File: rtl/iob_cache_axi_pkg.sv
// Shared definitions for the cache AXI subordinate RAM.
// Contents: write/read FSM state encodings and AXI response codes.
package iob_cache_axi_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/iob_regfile_2p.sv
// Register-file RAM: one synchronous write port with byte enables and one
// asynchronous read port. Contents are never reset.
// Ports: clk_i clock; we_i write enable; be_i per-byte enables; waddr_i/wdata_i
// write address/data; raddr_i read address; rdata_o read data (combinational).
module iob_regfile_2p #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (we_i && be_i[b]) begin
                mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // A read of the word being written returns the old value; the write lands at the edge.
    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/iob_cache_axi_ram_sub.sv
// AXI4 subordinate backed by an internal register-file RAM.
// Serves INCR read/write bursts; write (AW/W/B) and read (AR/R) paths are
// independent FSMs and may be active at the same time.
// Ports: clk_i/cke_i/arst_i clock, clock enable, async active-high reset;
// axi_aw*/axi_w*/axi_b* write channel; axi_ar*/axi_r* read channel.
// Burst type, size, lock, cache and qos are accepted and ignored.
module iob_cache_axi_ram_sub
    import iob_cache_axi_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [3:0]              axi_awqos_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [3:0]              axi_arqos_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int NB_W = $clog2(AXI_DATA_W/8);
    localparam logic [MEM_ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [AXI_LEN_W-1:0]  CNT_ONE = 1;

    w_state_t              w_state;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic [AXI_ID_W-1:0]   w_id;
    logic [AXI_LEN_W-1:0]  w_len;
    logic [AXI_LEN_W-1:0]  w_cnt;
    logic                  w_err;

    r_state_t              r_state;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_LEN_W-1:0]  r_len;
    logic [AXI_LEN_W-1:0]  r_cnt;

    logic                  w_hs;
    logic [AXI_DATA_W-1:0] mem_rdata;

    // Attributes this RAM does not interpret, plus address bits outside the word index.
    logic unused_attr;
    assign unused_attr = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i, axi_awqos_i,
                           axi_arsize_i, axi_arburst_i, axi_arlock_i, axi_arcache_i, axi_arqos_i,
                           axi_awaddr_i, axi_araddr_i};

    // Readies are gated by cke_i so no handshake can complete while the clock is disabled.
    assign axi_awready_o = cke_i && (w_state == W_IDLE);
    assign axi_wready_o  = cke_i && (w_state == W_DATA);
    assign axi_arready_o = cke_i && (r_state == R_IDLE);

    assign axi_bvalid_o = (w_state == W_RESP);
    assign axi_bid_o    = axi_bvalid_o ? w_id : '0;
    assign axi_bresp_o  = (axi_bvalid_o && w_err) ? RESP_SLVERR : RESP_OKAY;

    assign axi_rvalid_o = (r_state == R_DATA);
    assign axi_rid_o    = axi_rvalid_o ? r_id : '0;
    assign axi_rdata_o  = axi_rvalid_o ? mem_rdata : '0;
    assign axi_rresp_o  = RESP_OKAY;
    assign axi_rlast_o  = axi_rvalid_o && (r_cnt == r_len);

    assign w_hs = axi_wvalid_i && axi_wready_o;

    iob_regfile_2p #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (AXI_DATA_W)
    ) u_regfile (
        .clk_i   (clk_i),
        .we_i    (w_hs),
        .be_i    (axi_wstrb_i),
        .waddr_i (w_idx),
        .wdata_i (axi_wdata_i),
        .raddr_i (r_idx),
        .rdata_o (mem_rdata)
    );

    // Write path: exactly len+1 beats are consumed; a misplaced wlast only flags SLVERR.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (cke_i) begin
            case (w_state)
                W_IDLE: begin
                    if (axi_awvalid_i) begin
                        w_idx   <= axi_awaddr_i[MEM_ADDR_W+NB_W-1:NB_W];
                        w_id    <= axi_awid_i;
                        w_len   <= axi_awlen_i;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid_i) begin
                        w_idx <= w_idx + IDX_ONE;
                        w_cnt <= w_cnt + CNT_ONE;
                        if (w_cnt == w_len) begin
                            w_err   <= w_err | ~axi_wlast_i;
                            w_state <= W_RESP;
                        end else begin
                            w_err <= w_err | axi_wlast_i;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready_i) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: the array read is combinational, so a beat is offered every cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (cke_i) begin
            case (r_state)
                R_IDLE: begin
                    if (axi_arvalid_i) begin
                        r_idx   <= axi_araddr_i[MEM_ADDR_W+NB_W-1:NB_W];
                        r_id    <= axi_arid_i;
                        r_len   <= axi_arlen_i;
                        r_cnt   <= '0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_rready_i) begin
                        r_idx <= r_idx + IDX_ONE;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == r_len) begin
                            r_state <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
